// File: rtl/sd_activity_monitor_if.sv
// Bus bundle for sd_activity_monitor: monitored lines, enables and
// mount controls in; activity, virtual-SD select and reset request out.
interface sd_activity_monitor_if #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned SIGS_PER_CH = 2
);
  logic [CHANNELS*SIGS_PER_CH-1:0] mon_sig;
  logic [CHANNELS-1:0]             ch_en;
  logic                            img_mounted;
  logic                            img_size_nz;
  logic                            vsd_sel;
  logic                            reset_img;
  logic [CHANNELS-1:0]             act;
  logic                            act_any;

  modport master (
    output mon_sig, ch_en, img_mounted, img_size_nz,
    input  vsd_sel, reset_img, act, act_any
  );

  modport slave (
    input  mon_sig, ch_en, img_mounted, img_size_nz,
    output vsd_sel, reset_img, act, act_any
  );
endinterface

// File: rtl/sd_activity_monitor.sv
// SD/virtual-SD/flash bus activity monitor with retriggerable per-channel
// activity flags, virtual-SD select latch and post-mount reset stretcher.
// Optional macro SD_ACT_SYNC_EN: adds a 2-flop input synchroniser plus
// post-reset toggle blanking ahead of the edge detector.
module sd_activity_monitor #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned SIGS_PER_CH = 2,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned RST_LEN     = 10000000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  sd_activity_monitor_if.slave  bus
);

  localparam int unsigned NS = CHANNELS * SIGS_PER_CH;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = (RST_LEN > 0) ? $clog2(RST_LEN + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_LEN);

  logic [NS-1:0]       sig_in;
  logic [NS-1:0]       old_sig;
  logic                tog_en;
  logic [CHANNELS-1:0] tog;
  logic [CHANNELS-1:0] act;
  logic [CW-1:0]       cnt [CHANNELS];
  logic [RW-1:0]       rst_cnt;
  logic                vsd_q;

`ifdef SD_ACT_SYNC_EN
  logic [NS-1:0] sync1;
  logic [NS-1:0] sync2;
  logic [1:0]    blank;

  // Two-flop synchroniser for every monitored line
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.mon_sig;
      sync2 <= sync1;
    end
  end

  // Blank toggles until old_sig holds a synchronised pin value; the
  // zero-reset chain needs three edges before old_sig catches up.
  always_ff @(posedge clk_sys) begin
    if (!reset_n)
      blank <= 2'd3;
    else if (blank != 2'd0)
      blank <= blank - 2'd1;
  end

  // Previous-sample register for edge detection
  always_ff @(posedge clk_sys) begin
    if (!reset_n)
      old_sig <= '0;
    else
      old_sig <= sig_in;
  end

  assign sig_in = sync2;
  assign tog_en = (blank == 2'd0);
`else
  // Previous-sample register; loading mon_sig during reset too means no
  // spurious toggle is seen on release
  always_ff @(posedge clk_sys) begin
    old_sig <= bus.mon_sig;
  end

  assign sig_in = bus.mon_sig;
  assign tog_en = 1'b1;
`endif

  // Any line of a channel changing since last cycle counts as a toggle
  always_comb begin
    tog = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      tog[i] = tog_en && (|(sig_in[i*SIGS_PER_CH +: SIGS_PER_CH] ^
                            old_sig[i*SIGS_PER_CH +: SIGS_PER_CH]));
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    // Saturating since-last-toggle counter; activity while below TIMEOUT
    always_ff @(posedge clk_sys) begin
      if (!reset_n || !bus.ch_en[g])
        cnt[g] <= CNT_MAX;
      else if (tog[g])
        cnt[g] <= '0;
      else if (cnt[g] < CNT_MAX)
        cnt[g] <= cnt[g] + CW'(1);
    end

    assign act[g] = (cnt[g] != CNT_MAX);
  end

  // Mount handling: latch virtual-SD select and (re)load the reset stretcher
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rst_cnt <= '0;
      vsd_q   <= 1'b0;
    end else if (bus.img_mounted) begin
      rst_cnt <= RST_LOAD;
      vsd_q   <= bus.img_size_nz;
    end else if (rst_cnt != '0) begin
      rst_cnt <= rst_cnt - RW'(1);
    end
  end

  assign bus.act       = act;
  assign bus.act_any   = |act;
  assign bus.reset_img = (rst_cnt != '0);
  assign bus.vsd_sel   = vsd_q;

endmodule

// File: tb/tb_sd_activity_monitor.sv
// Self-checking bench for sd_activity_monitor (default build): directed
// scenarios with literal expectations plus a randomized phase, all outputs
// compared every cycle against a time-stamp based reference model.
module tb_sd_activity_monitor;

  localparam int unsigned CH  = 2;
  localparam int unsigned SPC = 2;
  localparam int unsigned TO  = 8;
  localparam int unsigned RL  = 5;

  logic clk_sys = 1'b0;
  logic reset_n;

  sd_activity_monitor_if #(.CHANNELS(CH), .SIGS_PER_CH(SPC)) bus ();

  sd_activity_monitor #(
    .CHANNELS(CH), .SIGS_PER_CH(SPC), .TIMEOUT(TO), .RST_LEN(RL)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint a, input longint e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model: remembers the edge index of the last qualifying toggle
  // per channel and of the last mount; outputs follow from elapsed edges.
  longint      n = 0;
  logic [3:0]  prev;
  bit          lv [CH];
  longint      lt [CH];
  bit          mv = 0;
  longint      mt = 0;
  bit          vsd_m = 0;
  bit          mvalid = 0;

  always @(posedge clk_sys) begin
    n++;
    if (!reset_n) begin
      prev = bus.mon_sig;
      for (int i = 0; i < CH; i++) lv[i] = 0;
      mv = 0;
      vsd_m = 0;
      mvalid = 1;
    end else begin
      for (int i = 0; i < CH; i++) begin
        bit t;
        t = 0;
        for (int j = 0; j < SPC; j++)
          if (bus.mon_sig[i*SPC+j] != prev[i*SPC+j]) t = 1;
        if (!bus.ch_en[i]) lv[i] = 0;
        else if (t) begin
          lv[i] = 1;
          lt[i] = n;
        end
      end
      prev = bus.mon_sig;
      if (bus.img_mounted) begin
        mv = 1;
        mt = n;
        vsd_m = bus.img_size_nz;
      end
    end
  end

  // Per-cycle compare plus running high-cycle tallies for the directed tests
  int acc_act0 = 0, acc_act1 = 0, acc_rimg = 0;

  always @(negedge clk_sys) begin
    if (mvalid) begin
      logic [1:0] ea;
      for (int i = 0; i < CH; i++)
        ea[i] = lv[i] && ((n - lt[i]) < TO);
      chk("act", bus.act, ea);
      chk("act_any", bus.act_any, |ea);
      chk("reset_img", bus.reset_img, mv && ((n - mt) < RL));
      chk("vsd_sel", bus.vsd_sel, vsd_m);
    end
    acc_act0 += int'(bus.act[0]);
    acc_act1 += int'(bus.act[1]);
    acc_rimg += int'(bus.reset_img);
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk_sys);
    #1;
  endtask

  int s0, s1, sr;

  initial begin
    reset_n         = 1'b0;
    bus.mon_sig     = 4'b1010;
    bus.ch_en       = 2'b11;
    bus.img_mounted = 1'b0;
    bus.img_size_nz = 1'b0;
    step(3);
    chk("rst_act", bus.act, 0);
    chk("rst_rimg", bus.reset_img, 0);
    chk("rst_vsd", bus.vsd_sel, 0);

    // Quiet after release: no activity for 20 cycles
    reset_n = 1'b1;
    s0 = acc_act0; s1 = acc_act1;
    step(20);
    chk("quiet_act0", acc_act0 - s0, 0);
    chk("quiet_act1", acc_act1 - s1, 0);
    chk("quiet_vsd", bus.vsd_sel, 0);

    // Single toggle on bit0: exactly TIMEOUT cycles of act[0]
    bus.mon_sig[0] = ~bus.mon_sig[0];
    s0 = acc_act0; s1 = acc_act1;
    step(15);
    chk("tog0_len", acc_act0 - s0, 8);
    chk("tog0_ch1", acc_act1 - s1, 0);

    // Retoggle bit3 five edges later: window restarts, 13 cycles total
    bus.mon_sig[3] = ~bus.mon_sig[3];
    s1 = acc_act1;
    step(5);
    bus.mon_sig[3] = ~bus.mon_sig[3];
    step(15);
    chk("retog_len", acc_act1 - s1, 13);

    // Mount with nonzero size: vsd_sel set, 5-cycle pulse
    bus.img_mounted = 1'b1; bus.img_size_nz = 1'b1;
    sr = acc_rimg;
    step(1);
    bus.img_mounted = 1'b0;
    step(10);
    chk("mount_len", acc_rimg - sr, 5);
    chk("mount_vsd", bus.vsd_sel, 1);

    // Remount during pulse cycle 3 with zero size: pulse extends to 8
    bus.img_mounted = 1'b1; bus.img_size_nz = 1'b1;
    sr = acc_rimg;
    step(1);
    bus.img_mounted = 1'b0;
    step(2);
    bus.img_mounted = 1'b1; bus.img_size_nz = 1'b0;
    step(1);
    bus.img_mounted = 1'b0;
    step(10);
    chk("remount_len", acc_rimg - sr, 8);
    chk("remount_vsd", bus.vsd_sel, 0);

    // Masking: act drops on the next edge and toggles are ignored
    bus.mon_sig[1] = ~bus.mon_sig[1];
    step(2);
    chk("mask_pre", bus.act[0], 1);
    bus.ch_en = 2'b10;
    step(1);
    chk("mask_drop", bus.act[0], 0);
    s0 = acc_act0;
    bus.mon_sig[0] = ~bus.mon_sig[0];
    step(4);
    chk("mask_ignore", acc_act0 - s0, 0);
    bus.ch_en = 2'b11;
    step(12);

    // Reset mid-pulse and mid-activity, with a mount and toggle pending
    bus.img_mounted = 1'b1; bus.img_size_nz = 1'b1;
    step(1);
    bus.img_mounted = 1'b0;
    bus.mon_sig[2] = ~bus.mon_sig[2];
    step(2);
    reset_n = 1'b0;
    bus.img_mounted = 1'b1;
    bus.mon_sig[0] = ~bus.mon_sig[0];
    step(1);
    chk("rst2_act", bus.act, 0);
    chk("rst2_any", bus.act_any, 0);
    chk("rst2_rimg", bus.reset_img, 0);
    chk("rst2_vsd", bus.vsd_sel, 0);
    reset_n = 1'b1;
    bus.img_mounted = 1'b0;
    sr = acc_rimg; s0 = acc_act0;
    step(10);
    chk("rst2_nopulse", acc_rimg - sr, 0);
    chk("rst2_noact", acc_act0 - s0, 0);

    // Randomized phase checked cycle-by-cycle by the model
    for (int it = 0; it < 800; it++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0)
        bus.mon_sig = bus.mon_sig ^ 4'($urandom_range(0, 15));
      bus.ch_en = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      bus.img_mounted = ($urandom_range(0, 19) == 0);
      bus.img_size_nz = 1'($urandom_range(0, 1));
      step(1);
    end
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
